// File: rtl/seg_scan_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
package seg_scan_pkg;

  // Segment bit positions inside one digit pattern.
  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Logical (pre-polarity) off level of one segment, and a full 8-bit blank digit.
  localparam logic       SEG_OFF     = 1'b0;
  localparam logic [7:0] SEG_ALL_OFF = 8'h00;

  // Convert a logical level (1 = active) to the physical pin level.
  function automatic logic apply_pol(input logic value, input logic active_low);
    return value ^ active_low;
  endfunction

endpackage

// File: rtl/scan_slot_counter.sv
// Slot counter and digit index for the scan driver; wraps per frame, clears when disabled.
module scan_slot_counter #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SLOT_LOG2  = 16,
  parameter int unsigned DIM_W      = 4,
  localparam int unsigned IDX_W     = $clog2(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic [DIM_W-1:0] cnt_msbs,
  output logic             frame_last,
  output logic             frame_first
);

  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(NUM_DIGITS - 1);

  logic [SLOT_LOG2-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 slot_last;

  assign slot_last = &cnt_q;

  // Next state: count within a slot, step the digit on slot wrap, clear when disabled.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_last) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
    if (!en) begin
      cnt_d = '0;
      idx_d = '0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign idx         = idx_q;
  assign cnt_msbs    = cnt_q[SLOT_LOG2-1 -: DIM_W];
  assign frame_last  = slot_last && (idx_q == IdxLast);
  assign frame_first = (cnt_q == '0) && (idx_q == '0);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed seven-segment driver: frame-synchronous shadows, PWM dimming, blanking.
module seg_scan_mux
  import seg_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SEG_W      = 8,
  parameter int unsigned SLOT_LOG2  = 16,
  parameter int unsigned DIM_W      = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        en,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  input  logic [DIM_W-1:0]            brightness,
  output logic [NUM_DIGITS-1:0]       an,
  output logic [SEG_W-1:0]            sseg,
  output logic                        frame_start
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic [IDX_W-1:0] idx;
  logic [DIM_W-1:0] cnt_msbs;
  logic             frame_last;
  logic             frame_first;

  scan_slot_counter #(
    .NUM_DIGITS(NUM_DIGITS),
    .SLOT_LOG2 (SLOT_LOG2),
    .DIM_W     (DIM_W)
  ) u_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .idx        (idx),
    .cnt_msbs   (cnt_msbs),
    .frame_last (frame_last),
    .frame_first(frame_first)
  );

  logic [NUM_DIGITS-1:0][SEG_W-1:0] seg_sh_q;
  logic [NUM_DIGITS-1:0]            den_sh_q;
  logic [DIM_W-1:0]                 bri_sh_q;
  logic                             load;

  // Transparent while disabled, otherwise only snapshot on the frame's final cycle.
  assign load = !en || frame_last;

  // Shadow registers so a frame never mixes old and new patterns.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_sh_q <= '0;
      den_sh_q <= '0;
      bri_sh_q <= '0;
    end else if (load) begin
      seg_sh_q <= seg_in;
      den_sh_q <= digit_en;
      bri_sh_q <= brightness;
    end
  end

  logic                  lit;
  logic [NUM_DIGITS-1:0] an_log, an_d;
  logic [SEG_W-1:0]      sseg_log, sseg_d;

  // Lit decode: on-time occupies the first (brightness+1) sub-slots of each slot.
  always_comb begin
    lit      = en && den_sh_q[idx] && (cnt_msbs <= bri_sh_q);
    an_log   = '0;
    sseg_log = {SEG_W{SEG_OFF}};
    if (lit) begin
      an_log[idx] = 1'b1;
      sseg_log    = seg_sh_q[idx];
    end
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      an_d[i] = apply_pol(an_log[i], ACTIVE_LOW);
    end
    for (int i = 0; i < int'(SEG_W); i++) begin
      sseg_d[i] = apply_pol(sseg_log[i], ACTIVE_LOW);
    end
  end

  // Output registers at physical polarity; reset drives everything inactive.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      an          <= {NUM_DIGITS{apply_pol(1'b0, ACTIVE_LOW)}};
      sseg        <= {SEG_W{apply_pol(SEG_OFF, ACTIVE_LOW)}};
      frame_start <= 1'b0;
    end else begin
      an          <= an_d;
      sseg        <= sseg_d;
      frame_start <= en && frame_first;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux with a frame-position reference model.
module tb_seg_scan_mux;
  import seg_scan_pkg::*;

  localparam int ND    = 6;
  localparam int SW    = 8;
  localparam int SL2   = 4;
  localparam int DW    = 2;
  localparam int SLOT  = 1 << SL2;
  localparam int FRAME = ND * SLOT;
  localparam int LEVELS = 1 << DW;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              en;
  logic [ND*SW-1:0]  seg_in;
  logic [ND-1:0]     digit_en;
  logic [DW-1:0]     brightness;
  logic [ND-1:0]     an;
  logic [SW-1:0]     sseg;
  logic              frame_start;

  seg_scan_mux #(
    .NUM_DIGITS(ND),
    .SEG_W     (SW),
    .SLOT_LOG2 (SL2),
    .DIM_W     (DW),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .seg_in     (seg_in),
    .digit_en   (digit_en),
    .brightness (brightness),
    .an         (an),
    .sseg       (sseg),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ND-1:0] an;
    logic [SW-1:0] sseg;
    logic          fs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // Reference model: position within the frame plus snapshots of the inputs.
  int            m_pos;
  logic [SW-1:0] m_seg[ND];
  logic [ND-1:0] m_den;
  int            m_bri;

  function automatic exp_t blank();
    exp_t e;
    e.an   = '1;
    e.sseg = ~SEG_ALL_OFF;
    e.fs   = 1'b0;
    return e;
  endfunction

  task automatic model_edge();
    exp_t e;
    int   d, ph, on_time;
    e = blank();
    if (!reset_n) begin
      m_pos = 0;
      m_den = '0;
      m_bri = 0;
      for (int i = 0; i < ND; i++) m_seg[i] = '0;
    end else begin
      if (en) begin
        d       = m_pos / SLOT;
        ph      = m_pos % SLOT;
        on_time = (m_bri + 1) * SLOT / LEVELS;
        if (m_den[d] && ph < on_time) begin
          e.an    = '1;
          e.an[d] = 1'b0;
          e.sseg  = ~m_seg[d];
        end
        e.fs = (m_pos == 0);
      end
      if (!en || m_pos == FRAME - 1) begin
        for (int i = 0; i < ND; i++) m_seg[i] = seg_in[i*SW +: SW];
        m_den = digit_en;
        m_bri = int'(brightness);
      end
      m_pos = en ? (m_pos + 1) % FRAME : 0;
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Advance until the model's next displayed position lies in [lo, hi].
  task automatic wait_pos(input int lo, input int hi, input string name);
    int k = 0;
    while (!(m_pos >= lo && m_pos <= hi) && k < 4 * FRAME) begin
      tick();
      k++;
    end
    checks++;
    if (k >= 4 * FRAME) begin
      errors++;
      $display("FAIL %s: wait bound expired, pos=%0d required %0d..%0d", name, m_pos, lo, hi);
    end
  endtask

  function automatic logic [SW-1:0] rand_pat();
    int unsigned bits[SW] = '{SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G, SEG_DP};
    logic [SW-1:0] p = '0;
    for (int k = 0; k < SW; k++) p[bits[k]] = 1'($urandom_range(1, 0));
    return p;
  endfunction

  task automatic count_pats();
    for (int i = 0; i < ND; i++) seg_in[i*SW +: SW] = SW'(i + 1);
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (an !== e.an || sseg !== e.sseg || frame_start !== e.fs) begin
          errors++;
          $display("FAIL scan cycle %0d: got an=%b sseg=%h fs=%b, required an=%b sseg=%h fs=%b",
                   cycle, an, sseg, frame_start, e.an, e.sseg, e.fs);
        end
      end
    end
  end

  initial begin
    // Reset with all inputs active.
    reset_n    = 1'b0;
    en         = 1'b1;
    brightness = 2'd3;
    digit_en   = 6'h3F;
    count_pats();
    run(3);
    reset_n = 1'b1;
    run(FRAME);              // first frame blank
    run(2 * FRAME);          // full scan, brightness 3

    brightness = 2'd0;       // minimum brightness
    run(2 * FRAME);

    brightness = 2'd3;       // mid-frame change of digit 4
    run(FRAME);
    wait_pos(2 * SLOT + 1, 3 * SLOT - 2, "mid_frame_wait");
    seg_in[4*SW +: SW] = 8'hA5;
    run(2 * FRAME);

    digit_en = 6'b101010;    // blank mask
    run(2 * FRAME);
    digit_en = 6'h3F;
    run(FRAME);

    wait_pos(3 * SLOT + 2, 4 * SLOT - 6, "disable_wait");
    en = 1'b0;               // disable mid-scan
    run(2);
    seg_in[0 +: SW] = 8'h3C;
    brightness      = 2'd1;
    run(3);
    en = 1'b1;
    run(FRAME + 5);

    wait_pos(FRAME - 1, FRAME - 1, "frame_end_wait");
    en = 1'b0;               // disable coincides with frame-end load
    seg_in[SW +: SW] = 8'h81;
    run(2);
    en = 1'b1;
    run(FRAME);

    // Randomized traffic.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(7, 0) == 0) seg_in[$urandom_range(ND - 1, 0)*SW +: SW] = rand_pat();
      if ($urandom_range(31, 0) == 0) digit_en = ND'($urandom);
      if ($urandom_range(31, 0) == 0) brightness = DW'($urandom);
      if (en && $urandom_range(99, 0) == 0) en = 1'b0;
      else if (!en && $urandom_range(3, 0) == 0) en = 1'b1;
      reset_n = ($urandom_range(499, 0) != 0);
      tick();
    end
    reset_n = 1'b1;
    en      = 1'b1;
    run(2);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_mux.md
# seg_scan_mux

Parametrised, time-multiplexed driver for an N-digit common-anode or common-cathode seven-segment display with decimal point. It scans one digit per refresh slot at a programmable rate and applies per-digit blanking and PWM brightness. Input patterns are captured at frame boundaries so the display never tears. The block sits between the digit-encoding logic (hex/BCD to segment) and the board display pins.

## Interface
- `NUM_DIGITS`, 8: digits scanned. Must be 2 or more; need not be a power of two.
- `SEG_W`, 8: segment bits per digit. `[6:0]`=a..g, `[7]`=dp.
- `SLOT_LOG2`, 16: log2 of the clock cycles per digit slot.
- `DIM_W`, 4: brightness width. Must satisfy `DIM_W <= SLOT_LOG2`.
- `ACTIVE_LOW`, 1: 1 means anodes and segments are driven low-active; 0 means high-active.
- `clk` input, 1: system clock.
- `reset_n` input, 1: reset, synchronous, active-low.
- `en` input, 1: scan enable.
- `seg_in` input, `NUM_DIGITS*SEG_W`: logical segment patterns, 1 = lit. Digit i is at `[i*SEG_W +: SEG_W]`.
- `digit_en` input, `NUM_DIGITS`: per-digit enable. 0 blanks that digit.
- `brightness` input, `DIM_W`: duty control.
- `an` output, `NUM_DIGITS`: digit selects, at the physical polarity.
- `sseg` output, `SEG_W`: segment drives, at the physical polarity.
- `frame_start` output, 1: one-cycle pulse on the first output cycle of digit 0.

## Operation
- **Slot counter:** `cnt` is `SLOT_LOG2` bits, free-running while `en`=1. Digit index `idx` is `$clog2(NUM_DIGITS)` bits. `idx` advances when `cnt` is all ones, wrapping from `NUM_DIGITS-1` to 0. Unused index codes never occur.
- **Shadow registers:** `seg_sh`, `den_sh` and `bri_sh` load from the inputs under either of two conditions:
  - `en`=0, every cycle (transparent);
  - the last cycle of a frame (`idx=NUM_DIGITS-1`, `cnt` all ones).
- **Shadow holds:** at all other times the shadows hold. Input changes made mid-frame appear from the next frame only.
- **Lit condition:** `lit = en & den_sh[idx] & (cnt[SLOT_LOG2-1 -: DIM_W] <= bri_sh)`.
- **Duty:** duty is `(brightness+1)/2^DIM_W`. The on-time sits at the start of each slot. Brightness all ones gives a 100% duty cycle.
- **Registered outputs:** when `lit`=1, `an` has only bit `idx` active and `sseg` = `seg_sh[idx]`. Otherwise all anodes are inactive and `sseg` is all segments off. Polarity is applied at the output register: invert when `ACTIVE_LOW`=1.
- **Blanking:** `sseg` is forced off whenever the anodes are off, which prevents ghosting.
- **Disable:** `en`=0 clears `cnt` and `idx` to 0. Outputs go inactive on the next cycle. On re-enable, scanning restarts at digit 0 with a fresh snapshot.
- **Reset:** `reset_n`=0 overrides `en` and clears `cnt`, `idx` and all shadows. The first frame after reset is therefore fully blank.

## Timing
- **Reset values:** all `an` inactive (all ones if `ACTIVE_LOW`, else zeros). All `sseg` off at the same polarity. `frame_start`=0.
- **Latency:** outputs lag the `(idx, cnt)` state by exactly 1 cycle.
- **`frame_start`:** registered. It is high for the one cycle after the state `idx=0, cnt=0` with `en`=1. Period is `NUM_DIGITS*2^SLOT_LOG2` cycles.
- **Reset mid-frame:** on the edge where `reset_n` is sampled low, outputs are inactive one cycle later. The same rule applies to `en` falling.
- **Digit slot:** each digit owns `2^SLOT_LOG2` consecutive output cycles. No inter-digit dead time is added beyond the brightness off-time.
- **Simultaneous events:** if the end-of-frame load coincides with `en` falling, the shadows still load; both conditions select a load.

## Structure
- **Package `seg_scan_pkg`:**
  - segment bit-index constants (a..g, dp);
  - all-off pattern constant;
  - `apply_pol(value, active_low)` function.
- **Sub-module `scan_slot_counter`:**
  - `cnt`/`idx` counters with wrap and enable;
  - outputs `idx`, `cnt_msbs`, `frame_last` and `frame_first`.
- **Top level:** shadows, lit decode and output registers.

## Test plan
All scenarios use `NUM_DIGITS=6`, `SLOT_LOG2=4`, `DIM_W=2`, `ACTIVE_LOW=1`.
1. **Reset:** hold `reset_n`=0 for 3 cycles with `en`=1 and all inputs set. Required:
   - `an`=6'b111111, `sseg`=8'hFF and `frame_start`=0 during reset;
   - the first 96-cycle frame after release stays fully blank.
2. **Full scan:** set `brightness`=3, `digit_en`=6'h3F, digit i pattern = i+1. Required:
   - each anode is low for 16 consecutive cycles, in order 0 to 5;
   - `sseg` = ~(i+1) during digit i;
   - the scan wraps to digit 0 after 96 cycles;
   - `frame_start` pulses every 96 cycles.
3. **Minimum brightness:** set `brightness`=0. Required:
   - each anode is low only for the first 4 cycles of its slot;
   - `sseg`=8'hFF for the remaining 12 cycles.
4. **Mid-frame change:** change digit 4's pattern while digit 2 is displayed. Required:
   - digit 4 shows the old value in this frame;
   - digit 4 shows the new value from the next `frame_start`.
5. **Blank mask:** set `digit_en`=6'b101010. Required:
   - anodes 0, 2 and 4 stay high;
   - `sseg`=8'hFF during those slots;
   - digits 1, 3 and 5 display normally.
6. **Disable mid-scan:** drop `en` to 0 during digit 3, then raise it after 5 cycles. Required:
   - all anodes go high 1 cycle after the drop;
   - after re-enable, digit 0 is active 1 cycle later, with `frame_start`=1 and the newest inputs.
